// File: rtl/simd_addsub_pipe.sv
// Pipelined SIMD add/subtract unit: run-time lane width, carry-in, wrap or saturating
// results, per-lane carry/overflow flags, valid/ready handshake with full backpressure.
module simd_addsub_pipe #(
  parameter int DATA_W = 64,
  parameter int LAT    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [DATA_W/8-1:0] cin,
  input  logic [1:0]          lane,
  input  logic                sub,
  input  logic                use_cin,
  input  logic [1:0]          sat,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   res,
  output logic [DATA_W/8-1:0] cout,
  output logic [DATA_W/8-1:0] ovf
);
  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = $clog2(NB);

  logic [IDX_W-1:0]  lane_mask;
  logic [NB-1:0]     lane_c;
  logic [NB-1:0]     byte_carry;
  logic [NB-1:0]     byte_ovf;
  logic [NB-1:0]     a_msb;
  logic [NB-1:0]     cout_c;
  logic [NB-1:0]     ovf_c;
  logic [DATA_W-1:0] sum_w;
  logic [DATA_W-1:0] sum_sat;
  logic              carry;
  logic [7:0]        bx;
  logic [8:0]        bsum;

  always_comb begin
    case (lane)
      2'd0:    lane_mask = IDX_W'(0);
      2'd1:    lane_mask = IDX_W'(1);
      2'd2:    lane_mask = IDX_W'(3);
      default: lane_mask = IDX_W'(7);
    endcase
  end

  assign lane_c = use_cin ? cin : {NB{sub}};

  // Byte-wise ripple; the chain restarts with the lane's own carry at each lane boundary.
  always_comb begin
    carry      = 1'b0;
    bx         = '0;
    bsum       = '0;
    sum_w      = '0;
    byte_carry = '0;
    byte_ovf   = '0;
    for (int i = 0; i < NB; i++) begin
      bx = sub ? ~b[8*i +: 8] : b[8*i +: 8];
      if ((IDX_W'(i) & lane_mask) == '0) carry = lane_c[i];
      bsum          = {1'b0, a[8*i +: 8]} + {1'b0, bx} + {8'd0, carry};
      carry         = bsum[8];
      sum_w[8*i +: 8] = bsum[7:0];
      byte_carry[i] = bsum[8];
      byte_ovf[i]   = (a[8*i+7] == bx[7]) && (bsum[7] != a[8*i+7]);
    end
  end

  for (genvar gi = 0; gi < NB; gi++) begin : g_sat
    localparam logic [IDX_W-1:0] BI = IDX_W'(gi);
    logic             top;
    logic [IDX_W-1:0] top_idx;
    logic             l_carry;
    logic             l_ovf;
    logic             l_msb;
    logic [7:0]       r_byte;

    assign a_msb[gi] = a[8*gi+7];
    assign top       = (BI & lane_mask) == lane_mask;
    assign top_idx   = BI | lane_mask;
    assign l_carry   = byte_carry[top_idx];
    assign l_ovf     = byte_ovf[top_idx];
    assign l_msb     = a_msb[top_idx];

    always_comb begin
      r_byte = sum_w[8*gi +: 8];
      case (sat)
        2'd1: begin
          if (!sub && l_carry)     r_byte = 8'hFF;
          else if (sub && !l_carry) r_byte = 8'h00;
        end
        2'd2: begin
          if (l_ovf) r_byte = top ? {l_msb, {7{~l_msb}}} : {8{~l_msb}};
        end
        default: ;
      endcase
    end

    assign sum_sat[8*gi +: 8] = r_byte;
    assign cout_c[gi]         = top & byte_carry[gi];
    assign ovf_c[gi]          = top & byte_ovf[gi];
  end

  logic [LAT-1:0]    valid_q, valid_d;
  logic [DATA_W-1:0] res_q  [LAT];
  logic [DATA_W-1:0] res_d  [LAT];
  logic [NB-1:0]     cout_q [LAT];
  logic [NB-1:0]     cout_d [LAT];
  logic [NB-1:0]     ovf_q  [LAT];
  logic [NB-1:0]     ovf_d  [LAT];
  logic              stall;

  assign out_valid = valid_q[LAT-1];
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !rst && !stall;

  always_comb begin
    valid_d = valid_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (!stall) begin
      valid_d[0] = in_valid;
      res_d[0]   = sum_sat;
      cout_d[0]  = cout_c;
      ovf_d[0]   = ovf_c;
      for (int k = 1; k < LAT; k++) begin
        valid_d[k] = valid_q[k-1];
        res_d[k]   = res_q[k-1];
        cout_d[k]  = cout_q[k-1];
        ovf_d[k]   = ovf_q[k-1];
      end
    end
    if (flush) valid_d = '0;
  end

  // Only the valid bits need reset; payload of invalid stages is masked at the output.
  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
    res_q  <= res_d;
    cout_q <= cout_d;
    ovf_q  <= ovf_d;
  end

  assign res  = out_valid ? res_q[LAT-1]  : '0;
  assign cout = out_valid ? cout_q[LAT-1] : '0;
  assign ovf  = out_valid ? ovf_q[LAT-1]  : '0;

endmodule

// File: tb/tb_simd_addsub_pipe.sv
// Self-checking bench for simd_addsub_pipe: directed vector table, backpressure, flush,
// mid-stream reset and randomized traffic against a lane-level arithmetic model.
module tb_simd_addsub_pipe;
  localparam int DW  = 64;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, sub, use_cin, out_valid, out_ready;
  logic [63:0] a, b, res;
  logic [7:0]  cin, cout, ovf;
  logic [1:0]  lane, sat;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pop = 0;

  always #5 clk = ~clk;

  simd_addsub_pipe #(.DATA_W(DW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .lane(lane), .sub(sub), .use_cin(use_cin), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready), .res(res), .cout(cout), .ovf(ovf)
  );

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [7:0]  cin;
    logic [1:0]  lane;
    logic        sub;
    logic        use_cin;
    logic [1:0]  sat;
  } op_t;

  typedef struct packed {
    logic [63:0] res;
    logic [7:0]  cout;
    logic [7:0]  ovf;
  } out_t;

  typedef struct {
    op_t  op;
    out_t exp;
  } vec_t;

  out_t exp_q[$];
  logic prev_stall = 1'b0;
  logic prev_flush = 1'b0;
  out_t prev_out   = '0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Whole-lane arithmetic with wide integers.
  function automatic out_t model(input op_t o);
    out_t r;
    int   w, nl;
    r  = '0;
    w  = 8 << o.lane;
    nl = 64 / w;
    for (int l = 0; l < nl; l++) begin
      logic [64:0] av, bv, sum;
      logic [63:0] mask, s;
      logic        c, cy, am, bm, sm, of;
      mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      av   = {1'b0, (o.a >> (l * w)) & mask};
      bv   = {1'b0, (o.b >> (l * w)) & mask};
      if (o.sub) bv = {1'b0, ~bv[63:0] & mask};
      c    = o.use_cin ? o.cin[l * w / 8] : o.sub;
      sum  = av + bv + 65'(c);
      cy   = sum[w];
      s    = sum[63:0] & mask;
      am   = av[w-1];
      bm   = bv[w-1];
      sm   = s[w-1];
      of   = (am == bm) && (sm != am);
      if (o.sat == 2'd1) begin
        if (!o.sub && cy)     s = mask;
        else if (o.sub && !cy) s = 64'd0;
      end else if (o.sat == 2'd2 && of) begin
        s = am ? (64'd1 << (w - 1)) : (mask >> 1);
      end
      r.res = r.res | (s << (l * w));
      r.cout[(l + 1) * w / 8 - 1] = cy;
      r.ovf[(l + 1) * w / 8 - 1]  = of;
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic [63:0] va, input logic [63:0] vb, input logic [7:0] vcin,
                              input logic [1:0] vlane, input logic vsub, input logic vuc,
                              input logic [1:0] vsat, input logic [63:0] er, input logic [7:0] ec,
                              input logic [7:0] eo);
    vec_t v;
    v.op  = '{a: va, b: vb, cin: vcin, lane: vlane, sub: vsub, use_cin: vuc, sat: vsat};
    v.exp = '{res: er, cout: ec, ovf: eo};
    return v;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    logic [63:0] pick [4];
    pick[0] = {$urandom(), $urandom()};
    pick[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    pick[2] = 64'h7F7F_7FFF_7FFF_FFFF;
    pick[3] = 64'h8080_8000_8000_0000;
    o.a       = pick[$urandom_range(0, 3)];
    o.b       = ($urandom_range(0, 1) == 0) ? {$urandom(), $urandom()} : pick[$urandom_range(0, 3)];
    o.cin     = 8'($urandom());
    o.lane    = 2'($urandom());
    o.sub     = 1'($urandom());
    o.use_cin = 1'($urandom());
    o.sat     = 2'($urandom());
    return o;
  endfunction

  task automatic drive(input op_t o);
    a = o.a; b = o.b; cin = o.cin; lane = o.lane;
    sub = o.sub; use_cin = o.use_cin; sat = o.sat;
  endtask

  // Scoreboard / protocol monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall <= 1'b0;
      prev_flush <= 1'b0;
    end else begin
      check("in_ready_rule", 80'(in_ready), 80'(!(out_valid && !out_ready)));
      if (prev_stall && !prev_flush) begin
        check("stall_hold_valid", 80'(out_valid), 80'd1);
        check("stall_hold_data", {res, cout, ovf}, prev_out);
      end
      if (!out_valid) check("idle_zero", {res, cout, ovf}, 80'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_result: got res=%h with nothing outstanding", res);
        end else begin
          out_t e;
          e = exp_q.pop_front();
          n_pop++;
          check("sb_result", {res, cout, ovf}, e);
        end
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready)
        exp_q.push_back(model('{a: a, b: b, cin: cin, lane: lane, sub: sub, use_cin: use_cin, sat: sat}));
      prev_stall <= out_valid && !out_ready;
      prev_flush <= flush;
      prev_out   <= {res, cout, ovf};
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    drive(v.op);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      @(negedge clk);
      check($sformatf("vec%0d_early", idx), 80'(out_valid), 80'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check($sformatf("vec%0d_valid", idx), 80'(out_valid), 80'd1);
    check($sformatf("vec%0d_res", idx), 80'(res), 80'(v.exp.res));
    check($sformatf("vec%0d_cout", idx), 80'(cout), 80'(v.exp.cout));
    check($sformatf("vec%0d_ovf", idx), 80'(ovf), 80'(v.exp.ovf));
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int guard = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check({name, "_drained"}, 80'(exp_q.size()), 80'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    int   pops0;
    tbl[0] = mk(64'hFF01_0203_0405_0607, 64'h0101_0101_0101_0101, 8'h00, 2'd0, 1'b0, 1'b0, 2'd0,
                64'h0002_0304_0506_0708, 8'h80, 8'h00);
    tbl[1] = mk(64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 8'h00, 2'd3, 1'b0, 1'b0, 2'd1,
                64'hFFFF_FFFF_FFFF_FFFF, 8'h80, 8'h00);
    tbl[2] = mk(64'h8000, 64'h1, 8'h00, 2'd1, 1'b1, 1'b0, 2'd2, 64'h8000, 8'hAA, 8'h02);
    tbl[3] = mk(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 8'h01, 2'd3, 1'b0, 1'b1, 2'd0, 64'h0, 8'h80, 8'h00);
    tbl[4] = mk(64'h7F, 64'h01, 8'h00, 2'd0, 1'b0, 1'b0, 2'd2, 64'h7F, 8'h00, 8'h01);
    tbl[5] = mk(64'h5, 64'h7, 8'h00, 2'd2, 1'b1, 1'b0, 2'd1, 64'h0, 8'h80, 8'h00);
    tbl[6] = mk(64'h5, 64'h5, 8'h00, 2'd1, 1'b1, 1'b1, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 8'h00);

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive('0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 80'(out_valid), 80'd0);
    check("reset_outputs", {res, cout, ovf}, 80'd0);
    check("reset_in_ready", 80'(in_ready), 80'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_vec(tbl[i], i);
      $display("vec%0d lane=%0d sub=%0d sat=%0d -> res=%h cout=%h ovf=%h", i, tbl[i].op.lane,
               tbl[i].op.sub, tbl[i].op.sat, tbl[i].exp.res, tbl[i].exp.cout, tbl[i].exp.ovf);
    end

    // Backpressure: 8 back-to-back ops, consumer stalls 5 cycles mid-stream.
    pops0 = n_pop;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          int guard = 0;
          drive(rand_op());
          in_valid = 1'b1;
          forever begin
            @(negedge clk);
            if (in_ready || guard >= 50) break;
            @(posedge clk); #1;
            guard++;
          end
          if (guard >= 50) begin
            n_cmp++; n_bad++;
            $display("FAIL bp_accept_timeout: op %0d not accepted within 50 cycles", i);
          end
          @(posedge clk); #1;
          $display("bp op %0d accepted", i);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("bp");
    check("bp_result_count", 80'(n_pop - pops0), 80'd8);

    // Flush with two ops in flight and a third presented in the flush cycle.
    drive(rand_op()); in_valid = 1'b1;
    @(posedge clk); #1 drive(rand_op());
    @(posedge clk); #1 drive(rand_op()); flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 80'(out_valid), 80'd0);
    repeat (LAT + 2) @(posedge clk);
    #1;
    $display("flush sequence done");

    // Reset mid-stream with two ops in flight.
    drive(rand_op()); in_valid = 1'b1;
    @(posedge clk); #1 drive(rand_op());
    @(posedge clk); #1 in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", 80'(out_valid), 80'd0);
    check("rst_mid_res", 80'(res), 80'd0);
    repeat (LAT + 2) @(posedge clk);
    #1;
    run_vec(tbl[0], 100);
    $display("mid-stream reset sequence done");

    // Randomized traffic with random bubbles and backpressure.
    for (int c = 0; c < 400; c++) begin
      drive(rand_op());
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain("random");
    $display("random traffic done: %0d results popped in total", n_pop);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
